// File: rtl/param_fifo.sv
// Synchronous FIFO with a registered read port, threshold flags, flush and
// sticky overflow/underflow reporting. All status flags are decoded from count_q.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_SIZE   = 5,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [PTR_SIZE:0]     count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** PTR_SIZE;
    localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE + 1)'(DEPTH);
    localparam logic [PTR_SIZE:0] AF_C    = (PTR_SIZE + 1)'(AF_THRESH);
    localparam logic [PTR_SIZE:0] AE_C    = (PTR_SIZE + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_SIZE:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty_c, full_c;
    logic rd_acc, wr_acc;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == DEPTH_C);

    // Flush masks both requests, so it also suppresses the error conditions.
    assign rd_acc = !flush && rd_en && !empty_c;
    assign wr_acc = !flush && wr_en && (!full_c || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en && !wr_acc) overflow_d = 1'b1;
            if (rd_en && empty_c) underflow_d = 1'b1;
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign empty        = empty_c;
    assign full         = full_c;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: fill/overflow, full R+W, empty cases, wrap,
// flush with error clearing, and asynchronous reset in mid-stream.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_valid, empty, full, almost_empty, almost_full;
    logic [5:0] count;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_d;
    logic [7:0] last_d;

    always #5 clk = ~clk;

    param_fifo #(
        .DATA_WIDTH(8), .PTR_SIZE(5), .AF_THRESH(28), .AE_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".count"}, count, 0);
        check({tag, ".empty"}, empty, 1);
        check({tag, ".full"}, full, 0);
        check({tag, ".ae"}, almost_empty, 1);
        check({tag, ".af"}, almost_full, 0);
        check({tag, ".data_out"}, data_out, 0);
        check({tag, ".rd_valid"}, rd_valid, 0);
        check({tag, ".ovf"}, overflow, 0);
        check({tag, ".udf"}, underflow, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #3;
        check_reset_outputs("reset");
        step(); step();
        rst = 0;

        // Fill with 0x00..0x1F, then an overflowing write of 0xAA.
        for (int i = 0; i < 32; i++) begin
            wr_en = 1; data_in = 8'(i);
            step();
            check($sformatf("fill%0d.count", i), count, i + 1);
            check($sformatf("fill%0d.af", i), almost_full, (i + 1 >= 28) ? 1 : 0);
        end
        check("fill.full", full, 1);
        check("fill.ovf_before", overflow, 0);
        data_in = 8'hAA;
        step();
        check("ovf.flag", overflow, 1);
        check("ovf.count", count, 32);
        check("ovf.full", full, 1);
        wr_en = 0; clr_err = 1;
        step();
        clr_err = 0;
        check("clr.ovf", overflow, 0);

        // Read and write together while full.
        wr_en = 1; rd_en = 1; data_in = 8'h55;
        step();
        wr_en = 0;
        check("fullrw.data", data_out, 8'h00);
        check("fullrw.valid", rd_valid, 1);
        check("fullrw.count", count, 32);
        check("fullrw.full", full, 1);
        check("fullrw.ovf", overflow, 0);

        // Drain: 0x01..0x1F then 0x55; the dropped 0xAA never appears.
        for (int i = 0; i < 32; i++) begin
            rd_en = 1;
            step();
            check($sformatf("drain%0d.data", i), data_out, (i < 31) ? i + 1 : 8'h55);
            check($sformatf("drain%0d.valid", i), rd_valid, 1);
            check($sformatf("drain%0d.count", i), count, 31 - i);
            if (i == 0) check("drain.full_deassert", full, 0);
        end
        rd_en = 0;
        step();
        check("drained.valid", rd_valid, 0);
        check("drained.empty", empty, 1);
        check("drained.ae", almost_empty, 1);

        // Read on empty.
        rd_en = 1;
        step();
        rd_en = 0;
        check("emptyrd.udf", underflow, 1);
        check("emptyrd.valid", rd_valid, 0);
        check("emptyrd.data", data_out, 8'h55);
        clr_err = 1;
        step();
        clr_err = 0;
        check("clr.udf", underflow, 0);

        // Read+write on empty: write taken, read rejected.
        wr_en = 1; rd_en = 1; data_in = 8'h3C;
        step();
        wr_en = 0;
        check("emptyrw.count", count, 1);
        check("emptyrw.valid", rd_valid, 0);
        check("emptyrw.udf", underflow, 1);
        step();
        rd_en = 0;
        check("emptyrw.rd_data", data_out, 8'h3C);
        check("emptyrw.rd_valid", rd_valid, 1);
        check("emptyrw.count0", count, 0);
        clr_err = 1;
        step();
        clr_err = 0;

        // Wrap-around streaming at occupancy 20.
        for (int i = 0; i < 20; i++) begin
            wr_en = 1; data_in = 8'(8'h80 + i);
            model_q.push_back(data_in);
            step();
        end
        check("wrap.fill_count", count, 20);
        for (int j = 0; j < 100; j++) begin
            wr_en = 1; rd_en = 1; data_in = 8'(8'h94 + j);
            model_q.push_back(data_in);
            exp_d = model_q.pop_front();
            step();
            check($sformatf("wrap%0d.data", j), data_out, exp_d);
            check($sformatf("wrap%0d.count", j), count, 20);
        end
        wr_en = 0; rd_en = 0;
        check("wrap.ovf", overflow, 0);
        check("wrap.udf", underflow, 0);

        // Bring occupancy to 10, then flush alongside a write.
        for (int i = 0; i < 10; i++) begin
            rd_en = 1;
            exp_d = model_q.pop_front();
            step();
            check($sformatf("pre_flush%0d.data", i), data_out, exp_d);
        end
        rd_en = 0;
        last_d = exp_d;
        check("pre_flush.count", count, 10);
        flush = 1; wr_en = 1; data_in = 8'hEE;
        step();
        flush = 0; wr_en = 0;
        model_q.delete();
        check("flush.count", count, 0);
        check("flush.empty", empty, 1);
        check("flush.ovf", overflow, 0);
        check("flush.data_held", data_out, last_d);
        check("flush.valid", rd_valid, 0);

        // Set beats clear in the same cycle, then clear alone.
        rd_en = 1; clr_err = 1;
        step();
        rd_en = 0;
        check("clrset.udf", underflow, 1);
        step();
        clr_err = 0;
        check("clronly.udf", underflow, 0);

        // Asynchronous reset with a read in flight.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; data_in = 8'(8'h10 + i);
            step();
        end
        wr_en = 0; rd_en = 1;
        step();
        rd_en = 0;
        check("prerst.count", count, 7);
        check("prerst.valid", rd_valid, 1);
        check("prerst.data", data_out, 8'h10);
        #2 rst = 1;
        #1;
        check_reset_outputs("midrst");
        step();
        rst = 0;
        wr_en = 1; data_in = 8'hC7;
        step();
        wr_en = 0; rd_en = 1;
        check("postrst.count", count, 1);
        step();
        rd_en = 0;
        check("postrst.data", data_out, 8'hC7);
        check("postrst.valid", rd_valid, 1);
        check("postrst.empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO for buffering butterfly-stage operands between matrix pipeline stages. It adds a registered read port with a valid strobe, programmable almost-full and almost-empty thresholds, and simultaneous read/write while full. It also provides a synchronous flush and sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain.

## Interface
- DATA_WIDTH, 8, width of each stored word
- PTR_SIZE, 5, pointer width; DEPTH = 2**PTR_SIZE (power of two, so pointers wrap naturally)
- AF_THRESH, 28, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH)
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- rd_valid  out  1  data_out updated this cycle (one-cycle pulse per accepted read)
- empty, full  out  1  count == 0 / count == DEPTH
- almost_empty, almost_full  out  1  threshold flags
- count  out  PTR_SIZE+1  current occupancy, 0..DEPTH
- clr_err  in  1  clear sticky error flags
- overflow, underflow  out  1  sticky error flags

## Operation
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1). Memory is not reset.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write when full is accepted only alongside an accepted read.
- Both rd_en and wr_en while empty: the write is accepted and the read is rejected. There is no fall-through.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1 (mod DEPTH).
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (mod DEPTH); rd_valid <= 1.
- Without rd_acc: rd_valid <= 0 and data_out holds its last value.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- All flags are decoded from the count register only, so they change on the clock edge after the causing event.
- overflow is set when wr_en && !wr_acc. underflow is set when rd_en && empty.
- clr_err clears both error flags. If a set condition and clr_err occur in the same cycle, the set wins.
- flush (highest synchronous priority): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0.
  - wr_en and rd_en are ignored that cycle and raise no errors.
  - data_out and the error flags are unchanged.

## Timing
- Read latency is 1 cycle: rd_en is sampled at edge N; data_out is valid and rd_valid=1 after edge N, visible in cycle N+1.
- Back-to-back reads stream one word per cycle with rd_valid held high.
- Write-to-read latency is 1 cycle: a word written at edge N makes empty=0 after edge N, so it can be read at edge N+1 and appears after edge N+1.
- full deasserts one edge after an accepted read. Simultaneous read+write at full keeps full=1 and count=DEPTH.
- Pointer wrap from DEPTH-1 to 0 is seamless; data order is preserved across the wrap.
- rst asserted mid-stream forces all outputs to reset values immediately, without waiting for a clock edge. The first post-reset write is stored at address 0.

## Test plan
- Fill and overflow: 32 writes of 0x00..0x1F, then one more write of 0xAA. Required: full=1, count=32, almost_full set after the 28th write, overflow=1, and the 0xAA write is dropped. Draining then returns 0x00..0x1F in order, each with rd_valid=1 one cycle after its rd_en.
- Full simultaneous: at full, wr_en=rd_en=1 with data_in=0x55. Required: data_out=0x00, count stays 32, no overflow. 0x55 is read last after a full drain.
- Empty behaviour: at empty, rd_en alone gives underflow=1, rd_valid=0, data_out unchanged. At empty, wr_en=rd_en=1 with 0x3C gives count=1 and rd_valid=0; the next read returns 0x3C.
- Wrap-around: run 100 continuous write/read cycles at 20 words of occupancy. Required: output sequence equals input sequence, count holds 20, no error flags.
- Flush and error clear: with count=10, assert flush together with wr_en. Required: count=0, empty=1, no overflow, data_out held. Then clr_err together with a new underflow event leaves underflow=1; a second clr_err alone clears it.
- Reset mid-operation: assert rst between clock edges while rd_valid=1 and count=7. Required: all outputs return to reset values immediately; the following write/read returns the new data correctly.
